// File: rtl/s1d_seq_pkg.sv
// s1d_seq_pkg -- shared definitions for the S1D command sequencer.
// Holds opcode constants, register-file base addresses, parameter counts,
// the sequencer state enum and the cursor direction enum.
package s1d_seq_pkg;

    // Command opcodes
    localparam logic [7:0] OP_SYSSET   = 8'h40;
    localparam logic [7:0] OP_SCROLL   = 8'h44;
    localparam logic [7:0] OP_CSRFORM  = 8'h5D;
    localparam logic [7:0] OP_CGRAMADR = 8'h5C;
    localparam logic [7:0] OP_HDOTSCR  = 8'h5A;
    localparam logic [7:0] OP_OVLAY    = 8'h5B;
    localparam logic [7:0] OP_DISPOFF  = 8'h58;
    localparam logic [7:0] OP_DISPON   = 8'h59;
    localparam logic [7:0] OP_CSRW     = 8'h46;
    localparam logic [7:0] OP_MWRITE   = 8'h42;
    localparam logic [7:0] OP_CSRDIR_R = 8'h4C;
    localparam logic [7:0] OP_CSRDIR_L = 8'h4D;
    localparam logic [7:0] OP_CSRDIR_U = 8'h4E;
    localparam logic [7:0] OP_CSRDIR_D = 8'h4F;

    // Register-file base addresses
    localparam logic [4:0] BASE_SYSSET   = 5'h00;
    localparam logic [4:0] BASE_SCROLL   = 5'h08;
    localparam logic [4:0] BASE_CSRFORM  = 5'h12;
    localparam logic [4:0] BASE_CGRAMADR = 5'h14;
    localparam logic [4:0] BASE_HDOTSCR  = 5'h16;
    localparam logic [4:0] BASE_OVLAY    = 5'h17;
    localparam logic [4:0] BASE_DISP     = 5'h18;

    // Parameter counts
    localparam logic [3:0] CNT_SYSSET   = 4'd8;
    localparam logic [3:0] CNT_SCROLL   = 4'd10;
    localparam logic [3:0] CNT_CSRFORM  = 4'd2;
    localparam logic [3:0] CNT_CGRAMADR = 4'd2;
    localparam logic [3:0] CNT_ONE      = 4'd1;
    localparam logic [3:0] CNT_CSRW     = 4'd2;

    // SYSTEM SET parameter indices that carry the address pitch (AP)
    localparam logic [3:0] IDX_AP_LO = 4'd6;
    localparam logic [3:0] IDX_AP_HI = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        PARAM,
        MWRITE
    } seq_state_e;

    typedef enum logic [1:0] {
        DIR_RIGHT,
        DIR_LEFT,
        DIR_UP,
        DIR_DOWN
    } csr_dir_e;

endpackage

// File: rtl/s1d_seq_csr.sv
// s1d_seq_csr -- cursor address register, AP shadow and direction logic.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wdat[7:0]             byte used by all load strobes
//   csr_lo_we/csr_hi_we   load low/high byte of the cursor
//   ap_lo_we/ap_hi_we     load low/high byte of the AP shadow
//   adv                   advance cursor by one step in the current direction
//   dir_we/dir_val        set the cursor direction
//   csr[15:0]             current cursor address
module s1d_seq_csr
    import s1d_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wdat,
    input  logic        csr_lo_we,
    input  logic        csr_hi_we,
    input  logic        ap_lo_we,
    input  logic        ap_hi_we,
    input  logic        adv,
    input  logic        dir_we,
    input  csr_dir_e    dir_val,
    output logic [15:0] csr
);

    logic [15:0] csr_q, csr_d;
    logic [15:0] ap_q, ap_d;
    csr_dir_e    dir_q, dir_d;

    always_comb begin
        csr_d = csr_q;
        ap_d  = ap_q;
        dir_d = dir_q;
        if (csr_lo_we) csr_d[7:0]  = wdat;
        if (csr_hi_we) csr_d[15:8] = wdat;
        // All arithmetic wraps modulo 2^16 by construction of the 16-bit width.
        if (adv) begin
            case (dir_q)
                DIR_RIGHT: csr_d = csr_q + 16'd1;
                DIR_LEFT:  csr_d = csr_q - 16'd1;
                DIR_UP:    csr_d = csr_q - ap_q;
                DIR_DOWN:  csr_d = csr_q + ap_q;
                default:   csr_d = csr_q;
            endcase
        end
        if (ap_lo_we) ap_d[7:0]  = wdat;
        if (ap_hi_we) ap_d[15:8] = wdat;
        if (dir_we)   dir_d      = dir_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_q <= '0;
            ap_q  <= '0;
            dir_q <= DIR_RIGHT;
        end else begin
            csr_q <= csr_d;
            ap_q  <= ap_d;
            dir_q <= dir_d;
        end
    end

    assign csr = csr_q;

endmodule

// File: rtl/s1d_cmd_seq.sv
// s1d_cmd_seq -- host command sequencer for an S1D-style display controller.
// Decodes command/parameter bytes from the host, writes parameters to the
// register file, loads the cursor and streams MWRITE data to VRAM through a
// two-entry (output stage + skid buffer) queue.
// Optional feature: define SEQ_CSRDIR_EN to enable the cursor direction
// commands 0x4C..0x4F; otherwise direction stays right.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_stb, a0, din[7:0]         host write strobe, command flag, byte
//   reg_we, reg_addr, reg_wdat   register-file write port (one-cycle pulse)
//   vram_we, vram_rdy            VRAM request held until vram_rdy
//   vram_addr, vram_wdat         VRAM address/data, stable while vram_we
//   csr                          cursor address
//   disp_on                      display enable
//   ovf                          sticky VRAM overflow flag
module s1d_cmd_seq
    import s1d_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_stb,
    input  logic        a0,
    input  logic [7:0]  din,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [7:0]  reg_wdat,
    output logic        vram_we,
    input  logic        vram_rdy,
    output logic [15:0] vram_addr,
    output logic [7:0]  vram_wdat,
    output logic [15:0] csr,
    output logic        disp_on,
    output logic        ovf
);

    seq_state_e  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  base_q, base_d;
    logic        pcsr_q, pcsr_d;      // current parameter run targets csr (CSRW)
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdat_q, reg_wdat_d;
    logic        disp_on_q, disp_on_d;
    logic        ovf_q, ovf_d;
    logic        out_vld_q, out_vld_d;
    logic [15:0] out_addr_q, out_addr_d;
    logic [7:0]  out_dat_q, out_dat_d;
    logic        buf_vld_q, buf_vld_d;
    logic [15:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_dat_q, buf_dat_d;

    logic        csr_lo_we, csr_hi_we, ap_lo_we, ap_hi_we, push, dir_we;
    logic        accept, drop;
    csr_dir_e    dir_val;

    s1d_seq_csr u_csr (
        .clk       (clk),
        .rst       (rst),
        .wdat      (din),
        .csr_lo_we (csr_lo_we),
        .csr_hi_we (csr_hi_we),
        .ap_lo_we  (ap_lo_we),
        .ap_hi_we  (ap_hi_we),
        .adv       (push),
        .dir_we    (dir_we),
        .dir_val   (dir_val),
        .csr       (csr)
    );

    // A byte is only dropped when both slots are full and nothing leaves
    // this cycle; acceptance frees a slot for a same-cycle write.
    assign accept = out_vld_q & vram_rdy;
    assign drop   = out_vld_q & buf_vld_q & ~accept;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        pcsr_d     = pcsr_q;
        reg_we_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_wdat_d = reg_wdat_q;
        disp_on_d  = disp_on_q;
        ovf_d      = ovf_q;
        csr_lo_we  = 1'b0;
        csr_hi_we  = 1'b0;
        ap_lo_we   = 1'b0;
        ap_hi_we   = 1'b0;
        push       = 1'b0;
        dir_we     = 1'b0;
        dir_val    = DIR_RIGHT;

        if (wr_stb && a0) begin
            idx_d   = '0;
            pcsr_d  = 1'b0;
            state_d = IDLE;
            case (din)
                OP_SYSSET:   begin state_d = PARAM; base_d = BASE_SYSSET;   cnt_d = CNT_SYSSET;   end
                OP_SCROLL:   begin state_d = PARAM; base_d = BASE_SCROLL;   cnt_d = CNT_SCROLL;   end
                OP_CSRFORM:  begin state_d = PARAM; base_d = BASE_CSRFORM;  cnt_d = CNT_CSRFORM;  end
                OP_CGRAMADR: begin state_d = PARAM; base_d = BASE_CGRAMADR; cnt_d = CNT_CGRAMADR; end
                OP_HDOTSCR:  begin state_d = PARAM; base_d = BASE_HDOTSCR;  cnt_d = CNT_ONE;      end
                OP_OVLAY:    begin state_d = PARAM; base_d = BASE_OVLAY;    cnt_d = CNT_ONE;      end
                OP_DISPOFF:  begin state_d = PARAM; base_d = BASE_DISP; cnt_d = CNT_ONE; disp_on_d = 1'b0; end
                OP_DISPON:   begin state_d = PARAM; base_d = BASE_DISP; cnt_d = CNT_ONE; disp_on_d = 1'b1; end
                OP_CSRW:     begin state_d = PARAM; pcsr_d = 1'b1;      cnt_d = CNT_CSRW; end
                OP_MWRITE:   state_d = MWRITE;
`ifdef SEQ_CSRDIR_EN
                OP_CSRDIR_R: begin dir_we = 1'b1; dir_val = DIR_RIGHT; end
                OP_CSRDIR_L: begin dir_we = 1'b1; dir_val = DIR_LEFT;  end
                OP_CSRDIR_U: begin dir_we = 1'b1; dir_val = DIR_UP;    end
                OP_CSRDIR_D: begin dir_we = 1'b1; dir_val = DIR_DOWN;  end
`endif
                default: ;
            endcase
        end else if (wr_stb && state_q == PARAM) begin
            if (pcsr_q) begin
                csr_lo_we = (idx_q == 4'd0);
                csr_hi_we = (idx_q != 4'd0);
            end else begin
                reg_we_d   = 1'b1;
                reg_addr_d = base_q + {1'b0, idx_q};
                reg_wdat_d = din;
                ap_lo_we   = (base_q == BASE_SYSSET) && (idx_q == IDX_AP_LO);
                ap_hi_we   = (base_q == BASE_SYSSET) && (idx_q == IDX_AP_HI);
            end
            idx_d = idx_q + 4'd1;
            if (idx_q == cnt_q - 4'd1) state_d = IDLE;
        end else if (wr_stb && state_q == MWRITE) begin
            if (drop) ovf_d = 1'b1;
            else      push  = 1'b1;
        end

        // VRAM output stage + skid buffer
        out_vld_d  = out_vld_q;
        out_addr_d = out_addr_q;
        out_dat_d  = out_dat_q;
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_dat_d  = buf_dat_q;
        if (accept) begin
            if (buf_vld_q) begin
                out_addr_d = buf_addr_q;
                out_dat_d  = buf_dat_q;
                buf_vld_d  = push;
                if (push) begin
                    buf_addr_d = csr;
                    buf_dat_d  = din;
                end
            end else begin
                out_vld_d = push;
                if (push) begin
                    out_addr_d = csr;
                    out_dat_d  = din;
                end
            end
        end else if (push) begin
            if (!out_vld_q) begin
                out_vld_d  = 1'b1;
                out_addr_d = csr;
                out_dat_d  = din;
            end else begin
                buf_vld_d  = 1'b1;
                buf_addr_d = csr;
                buf_dat_d  = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            pcsr_q     <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_wdat_q <= '0;
            disp_on_q  <= 1'b0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_dat_q  <= '0;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            pcsr_q     <= pcsr_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_wdat_q <= reg_wdat_d;
            disp_on_q  <= disp_on_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_addr_q <= out_addr_d;
            out_dat_q  <= out_dat_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_dat_q  <= buf_dat_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdat  = reg_wdat_q;
    assign vram_we   = out_vld_q;
    assign vram_addr = out_addr_q;
    assign vram_wdat = out_dat_q;
    assign disp_on   = disp_on_q;
    assign ovf       = ovf_q;

endmodule
